// File: rtl/controle_fsm.sv
// controle_fsm: multi-cycle control unit for the 8-register processor datapath.
// Decodes a 10-bit instruction (opcode ir[9:6], X ir[5:3], Y ir[2:0]) and
// sequences steps T0..T3, driving register strobes, ALU controls and memory
// strobes. Optional macro COMPARE_EN enables the SLT/SGT compare instructions;
// without it those opcodes behave as NOPs and the compare outputs stay 0.
// Outputs are held in registers loaded with the decode of the step being
// entered, so they always equal the decode of (current step, ir) while ir is
// held stable for the instruction.
module controle_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic [9:0] ir,
  input  logic       run,
  output logic       r0_in,
  output logic       r1_in,
  output logic       r2_in,
  output logic       r3_in,
  output logic       r4_in,
  output logic       r5_in,
  output logic       r6_in,
  output logic       r7_in,
  output logic       r0_out,
  output logic       r1_out,
  output logic       r2_out,
  output logic       r3_out,
  output logic       r4_out,
  output logic       r5_out,
  output logic       r6_out,
  output logic       r7_out,
  output logic       a_in,
  output logic       g_in,
  output logic       g_out,
  output logic       add_sub,
  output logic       soma,
  output logic       comparacao,
  output logic       maior_menor,
  output logic       zero,
  output logic       dinout,
  output logic       memoria,
  output logic       addr_in,
  output logic       dout_in,
  output logic       wren,
  output logic       done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] r_in;
    logic [7:0] r_out;
    logic       a_in;
    logic       g_in;
    logic       g_out;
    logic       add_sub;
    logic       soma;
    logic       comparacao;
    logic       maior_menor;
    logic       zero;
    logic       dinout;
    logic       memoria;
    logic       addr_in;
    logic       dout_in;
    logic       wren;
    logic       done;
  } ctrl_t;

  localparam logic [3:0] OP_MV  = 4'b0000;
  localparam logic [3:0] OP_MVI = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_LD  = 4'b0100;
  localparam logic [3:0] OP_ST  = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b0110;
  localparam logic [3:0] OP_SGT = 4'b0111;
  localparam logic [3:0] OP_CLR = 4'b1000;

  // Control word for a given step and instruction; T0 and undefined steps give all zeros.
  function automatic ctrl_t decode(input state_t st, input logic [9:0] i);
    ctrl_t      c;
    logic [7:0] x_hot;
    logic [7:0] y_hot;
    c     = '0;
    x_hot = 8'd1 << i[5:3];
    y_hot = 8'd1 << i[2:0];
    case (st)
      T1: begin
        case (i[9:6])
          OP_MV: begin
            c.r_out = y_hot;
            c.r_in  = x_hot;
            c.done  = 1'b1;
          end
          OP_MVI: begin
            c.dinout = 1'b1;
            c.r_in   = x_hot;
            c.done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            c.r_out = x_hot;
            c.a_in  = 1'b1;
          end
`ifdef COMPARE_EN
          OP_SLT, OP_SGT: begin
            c.r_out = x_hot;
            c.a_in  = 1'b1;
          end
`endif
          OP_LD, OP_ST: begin
            c.r_out   = y_hot;
            c.addr_in = 1'b1;
          end
          OP_CLR: begin
            c.zero = 1'b1;
            c.r_in = x_hot;
            c.done = 1'b1;
          end
          default: begin
            c.done = 1'b1;
          end
        endcase
      end
      T2: begin
        case (i[9:6])
          OP_ADD, OP_SUB: begin
            c.r_out   = y_hot;
            c.g_in    = 1'b1;
            c.soma    = 1'b1;
            c.add_sub = i[6];
          end
`ifdef COMPARE_EN
          OP_SLT, OP_SGT: begin
            c.r_out       = y_hot;
            c.g_in        = 1'b1;
            c.comparacao  = 1'b1;
            c.add_sub     = 1'b1;
            c.maior_menor = i[6];
          end
`endif
          OP_ST: begin
            c.r_out   = x_hot;
            c.dout_in = 1'b1;
            c.wren    = 1'b1;
            c.done    = 1'b1;
          end
          default: begin
            c = '0;
          end
        endcase
      end
      T3: begin
        case (i[9:6])
          OP_ADD, OP_SUB: begin
            c.g_out = 1'b1;
            c.r_in  = x_hot;
            c.done  = 1'b1;
          end
`ifdef COMPARE_EN
          OP_SLT, OP_SGT: begin
            c.g_out = 1'b1;
            c.r_in  = x_hot;
            c.done  = 1'b1;
          end
`endif
          OP_LD: begin
            c.memoria = 1'b1;
            c.r_in    = x_hot;
            c.done    = 1'b1;
          end
          default: begin
            c = '0;
          end
        endcase
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  state_t state_r;
  state_t state_next;
  ctrl_t  ctrl_cur;
  ctrl_t  ctrl_r;

  // Next step: T0 waits for run, a done step returns to T0, otherwise advance.
  always_comb begin
    ctrl_cur   = decode(state_r, ir);
    state_next = T0;
    if (state_r == T0) begin
      if (run) begin
        state_next = T1;
      end else begin
        state_next = T0;
      end
    end else if (ctrl_cur.done) begin
      state_next = T0;
    end else begin
      case (state_r)
        T1:      state_next = T2;
        T2:      state_next = T3;
        default: state_next = T0;
      endcase
    end
  end

  // Step register and registered control word for the step being entered.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= T0;
      ctrl_r  <= '0;
    end else begin
      state_r <= state_next;
      ctrl_r  <= decode(state_next, ir);
    end
  end

  assign {r7_in, r6_in, r5_in, r4_in, r3_in, r2_in, r1_in, r0_in} = ctrl_r.r_in;
  assign {r7_out, r6_out, r5_out, r4_out, r3_out, r2_out, r1_out, r0_out} = ctrl_r.r_out;
  assign a_in        = ctrl_r.a_in;
  assign g_in        = ctrl_r.g_in;
  assign g_out       = ctrl_r.g_out;
  assign add_sub     = ctrl_r.add_sub;
  assign soma        = ctrl_r.soma;
  assign comparacao  = ctrl_r.comparacao;
  assign maior_menor = ctrl_r.maior_menor;
  assign zero        = ctrl_r.zero;
  assign dinout      = ctrl_r.dinout;
  assign memoria     = ctrl_r.memoria;
  assign addr_in     = ctrl_r.addr_in;
  assign dout_in     = ctrl_r.dout_in;
  assign wren        = ctrl_r.wren;
  assign done        = ctrl_r.done;

endmodule

// File: tb/tb_controle_fsm.sv
// Directed self-checking bench for controle_fsm. All outputs are packed into
// one 30-bit word and compared against hand-built expected words.
module tb_controle_fsm;

  logic       clock;
  logic       resetn;
  logic [9:0] ir;
  logic       run;
  logic r0_in, r1_in, r2_in, r3_in, r4_in, r5_in, r6_in, r7_in;
  logic r0_out, r1_out, r2_out, r3_out, r4_out, r5_out, r6_out, r7_out;
  logic a_in, g_in, g_out, add_sub, soma, comparacao, maior_menor;
  logic zero, dinout, memoria, addr_in, dout_in, wren, done;

  int checks;
  int failures;

  controle_fsm dut (
    .clock(clock), .resetn(resetn), .ir(ir), .run(run),
    .r0_in(r0_in), .r1_in(r1_in), .r2_in(r2_in), .r3_in(r3_in),
    .r4_in(r4_in), .r5_in(r5_in), .r6_in(r6_in), .r7_in(r7_in),
    .r0_out(r0_out), .r1_out(r1_out), .r2_out(r2_out), .r3_out(r3_out),
    .r4_out(r4_out), .r5_out(r5_out), .r6_out(r6_out), .r7_out(r7_out),
    .a_in(a_in), .g_in(g_in), .g_out(g_out), .add_sub(add_sub), .soma(soma),
    .comparacao(comparacao), .maior_menor(maior_menor), .zero(zero),
    .dinout(dinout), .memoria(memoria), .addr_in(addr_in), .dout_in(dout_in),
    .wren(wren), .done(done)
  );

  localparam logic [29:0] A_IN  = 30'd1 << 13;
  localparam logic [29:0] G_IN  = 30'd1 << 12;
  localparam logic [29:0] G_OUT = 30'd1 << 11;
  localparam logic [29:0] ASUB  = 30'd1 << 10;
  localparam logic [29:0] SOMA  = 30'd1 << 9;
  localparam logic [29:0] COMP  = 30'd1 << 8;
  localparam logic [29:0] MM    = 30'd1 << 7;
  localparam logic [29:0] ZERO  = 30'd1 << 6;
  localparam logic [29:0] DIN   = 30'd1 << 5;
  localparam logic [29:0] MEM   = 30'd1 << 4;
  localparam logic [29:0] ADDR  = 30'd1 << 3;
  localparam logic [29:0] DOUT  = 30'd1 << 2;
  localparam logic [29:0] WREN  = 30'd1 << 1;
  localparam logic [29:0] DONE  = 30'd1;
  localparam logic [29:0] NONE  = 30'd0;

  function automatic logic [29:0] rin(input int n);
    return 30'd1 << (22 + n);
  endfunction

  function automatic logic [29:0] rout(input int n);
    return 30'd1 << (14 + n);
  endfunction

  function automatic logic [29:0] obs_word();
    return {r7_in, r6_in, r5_in, r4_in, r3_in, r2_in, r1_in, r0_in,
            r7_out, r6_out, r5_out, r4_out, r3_out, r2_out, r1_out, r0_out,
            a_in, g_in, g_out, add_sub, soma, comparacao, maior_menor,
            zero, dinout, memoria, addr_in, dout_in, wren, done};
  endfunction

  // clock generation
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Issue one instruction with run pulsed in T0, check each step, then the return to T0.
  task automatic do_instr(input string tag, input logic [9:0] i, input int n,
                          input logic [29:0] e1, input logic [29:0] e2, input logic [29:0] e3);
    logic [29:0] exp_s [3];
    exp_s[0] = e1;
    exp_s[1] = e2;
    exp_s[2] = e3;
    @(negedge clock);
    ir  = i;
    run = 1'b1;
    for (int s = 0; s < n; s++) begin
      @(posedge clock);
      #1;
      check_val($sformatf("%s_T%0d", tag, s + 1), obs_word(), exp_s[s]);
      run = 1'b0;
    end
    @(posedge clock);
    #1;
    check_val($sformatf("%s_idle", tag), obs_word(), NONE);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    run      = 1'b0;
    ir       = 10'd0;
    repeat (2) @(posedge clock);
    #1;
    check_val("reset", obs_word(), NONE);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check_val("idle_no_run", obs_word(), NONE);

    do_instr("mvi_r0", 10'b0001000000, 1, DIN | rin(0) | DONE, NONE, NONE);
    do_instr("mv_r1_r0", 10'b0000001000, 1, rout(0) | rin(1) | DONE, NONE, NONE);
    do_instr("add_r1_r1", 10'b0010001001, 3, rout(1) | A_IN,
             rout(1) | G_IN | SOMA, G_OUT | rin(1) | DONE);
    do_instr("sub_r2_r0", 10'b0011010000, 3, rout(2) | A_IN,
             rout(0) | G_IN | SOMA | ASUB, G_OUT | rin(2) | DONE);
    do_instr("ld_r3_r4", 10'b0100011100, 3, rout(4) | ADDR, NONE, MEM | rin(3) | DONE);
    do_instr("st_r3_r4", 10'b0101011100, 2, rout(4) | ADDR,
             rout(3) | DOUT | WREN | DONE, NONE);
    do_instr("clr_r7", 10'b1000111000, 1, ZERO | rin(7) | DONE, NONE, NONE);
    do_instr("nop_1111", 10'b1111101010, 1, DONE, NONE, NONE);
`ifdef COMPARE_EN
    do_instr("slt_r2_r1", 10'b0110010001, 3, rout(2) | A_IN,
             rout(1) | G_IN | COMP | ASUB, G_OUT | rin(2) | DONE);
    do_instr("sgt_r5_r6", 10'b0111101110, 3, rout(5) | A_IN,
             rout(6) | G_IN | COMP | ASUB | MM, G_OUT | rin(5) | DONE);
`else
    do_instr("slt_nop", 10'b0110010001, 1, DONE, NONE, NONE);
    do_instr("sgt_nop", 10'b0111101110, 1, DONE, NONE, NONE);
`endif

    // back-to-back with run held high: T1, T0, T1 again
    @(negedge clock);
    ir  = 10'b0001011000;
    run = 1'b1;
    @(posedge clock);
    #1;
    check_val("b2b_first", obs_word(), DIN | rin(3) | DONE);
    @(posedge clock);
    #1;
    check_val("b2b_t0", obs_word(), NONE);
    @(posedge clock);
    #1;
    check_val("b2b_second", obs_word(), DIN | rin(3) | DONE);
    run = 1'b0;
    @(posedge clock);
    #1;
    check_val("b2b_idle", obs_word(), NONE);

    // asynchronous reset in T2 of ADD
    @(negedge clock);
    ir  = 10'b0010001001;
    run = 1'b1;
    @(posedge clock);
    #1;
    check_val("rst_add_T1", obs_word(), rout(1) | A_IN);
    run = 1'b0;
    @(posedge clock);
    #1;
    check_val("rst_add_T2", obs_word(), rout(1) | G_IN | SOMA);
    #2;
    resetn = 1'b0;
    #1;
    check_val("rst_async", obs_word(), NONE);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check_val("rst_after1", obs_word(), NONE);
    @(posedge clock);
    #1;
    check_val("rst_after2", obs_word(), NONE);

    // the interrupted instruction must restart cleanly
    do_instr("add_after_rst", 10'b0010001001, 3, rout(1) | A_IN,
             rout(1) | G_IN | SOMA, G_OUT | rin(1) | DONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
